kernel_run_sched: RTL and testbench

Run scheduler for an HLS kernel using the ap_ctrl_hs handshake, such as the mvt kernel and its kernel_ram input banks. It sits between the VIO start probe and the kernel's ap_start/ap_done port. On a start request it launches a programmed number of back-to-back kernel runs, or runs continuously, with a fixed idle gap between runs. It tracks the dataset index that the kernel_ram banks advance on each ap_done, measures per-run latency, and stops the kernel with an error flag if a run hangs.

---
 rtl/kernel_run_sched.sv | 161 ++++++++++++++++
 tb/tb_kernel_run_sched.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/kernel_run_sched.sv
// Run scheduler for an ap_ctrl_hs kernel: launches N (or endless) runs with an idle gap,
// tracks the kernel_ram dataset index, measures run latency and aborts hung runs.
module kernel_run_sched #(
  parameter int DATASET_NUM    = 8,
  parameter int RUN_W          = 16,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int CYC_W          = 32,
  localparam int DS_W          = (DATASET_NUM > 1) ? $clog2(DATASET_NUM) : 1
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             trigger,
  input  logic [RUN_W-1:0] run_count,
  output logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  input  logic             ap_idle,
  output logic             busy,
  output logic             done_all,
  output logic             timeout_err,
  output logic [RUN_W-1:0] run_idx,
  output logic [DS_W-1:0]  dataset_idx,
  output logic [CYC_W-1:0] last_cycles
);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {S_IDLE, S_WAIT_IDLE, S_START, S_RUN, S_GAP, S_ERR} state_t;
  state_t state;

  // Reset asserts asynchronously, releases two edges later on ap_clk.
  logic [1:0] rst_pipe;
  logic       rst_n;
  always_ff @(posedge ap_clk or negedge ap_rst_n)
    if (!ap_rst_n) rst_pipe <= '0;
    else           rst_pipe <= {rst_pipe[0], 1'b1};
  assign rst_n = rst_pipe[1];

  logic [1:0] trig_sync;
  logic       trig_d, trig_rise, trig_fall;
  always_ff @(posedge ap_clk or negedge rst_n)
    if (!rst_n) begin
      trig_sync <= '0;
      trig_d    <= 1'b0;
      trig_rise <= 1'b0;
      trig_fall <= 1'b0;
    end else begin
      trig_sync <= {trig_sync[0], trigger};
      trig_d    <= trig_sync[1];
      trig_rise <= trig_sync[1] & ~trig_d;
      trig_fall <= ~trig_sync[1] & trig_d;
    end

  logic [CYC_W-1:0] cyc;
  logic [TO_W-1:0]  tcnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [RUN_W-1:0] tgt, run_nxt;
  logic [DS_W-1:0]  ds_nxt;
  logic             cont, stop_req;
  logic             in_run, seq_end, tmo, gap_last, launch;

  assign run_nxt  = run_idx + 1'b1;
  assign ds_nxt   = (dataset_idx == DS_W'(DATASET_NUM - 1)) ? '0 : dataset_idx + 1'b1;
  assign in_run   = (state == S_START) || (state == S_RUN);
  assign seq_end  = cont ? stop_req : (run_nxt == tgt);
  assign tmo      = (tcnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign gap_last = (gap_cnt == GAP_W'(GAP_CYCLES - 1));

  // Every path into START funnels through launch so cyc/tcnt restart in one place.
  always_comb begin
    launch = 1'b0;
    case (state)
      S_IDLE, S_ERR:  launch = trig_rise && ap_idle;
      S_WAIT_IDLE:    launch = ap_idle;
      S_START, S_RUN: launch = ap_done && !seq_end && (GAP_CYCLES == 0);
      S_GAP:          launch = !stop_req && gap_last;
      default:        launch = 1'b0;
    endcase
  end

  always_ff @(posedge ap_clk or negedge rst_n)
    if (!rst_n) begin
      state       <= S_IDLE;
      ap_start    <= 1'b0;
      busy        <= 1'b0;
      done_all    <= 1'b0;
      timeout_err <= 1'b0;
      run_idx     <= '0;
      dataset_idx <= '0;
      last_cycles <= '0;
      cyc         <= '0;
      tcnt        <= '0;
      gap_cnt     <= '0;
      tgt         <= '0;
      cont        <= 1'b0;
      stop_req    <= 1'b0;
    end else begin
      done_all <= 1'b0;
      if (trig_fall && cont && busy) stop_req <= 1'b1;
      if (in_run) begin
        cyc  <= (&cyc) ? cyc : cyc + 1'b1;
        tcnt <= tcnt + 1'b1;
      end
      case (state)
        S_IDLE, S_ERR: if (trig_rise) begin
          tgt         <= run_count;
          run_idx     <= '0;
          cont        <= (run_count == '0);
          timeout_err <= 1'b0;
          stop_req    <= 1'b0;
          busy        <= 1'b1;
          if (!ap_idle) state <= S_WAIT_IDLE;
        end
        S_START, S_RUN: begin
          if (ap_done) begin
            last_cycles <= cyc;
            run_idx     <= run_nxt;
            dataset_idx <= ds_nxt;
            if (seq_end) begin
              state    <= S_IDLE;
              ap_start <= 1'b0;
              busy     <= 1'b0;
              done_all <= 1'b1;
              stop_req <= 1'b0;
            end else if (GAP_CYCLES != 0) begin
              state    <= S_GAP;
              ap_start <= 1'b0;
              gap_cnt  <= '0;
            end
          end else if (tmo) begin
            state       <= S_ERR;
            ap_start    <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
          end else if (state == S_START && ap_ready) begin
            state    <= S_RUN;
            ap_start <= 1'b0;
          end
        end
        S_GAP: begin
          if (stop_req) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done_all <= 1'b1;
            stop_req <= 1'b0;
          end else if (!gap_last) begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        S_WAIT_IDLE: ;
        default: state <= S_IDLE;
      endcase
      if (launch) begin
        state    <= S_START;
        ap_start <= 1'b1;
        cyc      <= CYC_W'(1);
        tcnt     <= '0;
      end
    end
endmodule

// File: tb/tb_kernel_run_sched.sv
// Directed/randomised bench for kernel_run_sched: DUT a (gap 16) and DUT b (gap 0, timeout 64)
// driven by small kernel models, checked against arithmetic expectations.
module tb_kernel_run_sched;
  logic        ap_clk = 1'b0, ap_rst_n;
  logic        a_trig, a_start, a_ready, a_done, a_idle, a_busy, a_done_all, a_to;
  logic [15:0] a_rc, a_run;
  logic [2:0]  a_ds;
  logic [31:0] a_last;
  logic        b_trig, b_start, b_ready, b_done, b_idle, b_busy, b_done_all, b_to;
  logic [15:0] b_rc, b_run;
  logic [2:0]  b_ds;
  logic [31:0] b_last;

  int checks = 0, failures = 0;
  int cyc_n = 0;
  int a_lat, k_cnt;
  bit k_act = 0, b_hold = 0;
  int a_starts[$], b_starts[$];
  bit a_start_q = 0, b_start_q = 0;
  int a_dn_cnt = 0, a_last_dn = 0, a_da_cnt = 0, a_da_cyc = 0;
  int b_hi = 0, b_da_cnt = 0;

  always #5 ap_clk = ~ap_clk;
  always @(posedge ap_clk) cyc_n <= cyc_n + 1;

  kernel_run_sched #(.DATASET_NUM(8), .RUN_W(16), .GAP_CYCLES(16), .TIMEOUT_CYCLES(1024), .CYC_W(32)) dut_a (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .trigger(a_trig), .run_count(a_rc),
    .ap_start(a_start), .ap_ready(a_ready), .ap_done(a_done), .ap_idle(a_idle),
    .busy(a_busy), .done_all(a_done_all), .timeout_err(a_to), .run_idx(a_run),
    .dataset_idx(a_ds), .last_cycles(a_last));

  kernel_run_sched #(.DATASET_NUM(8), .RUN_W(16), .GAP_CYCLES(0), .TIMEOUT_CYCLES(64), .CYC_W(32)) dut_b (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .trigger(b_trig), .run_count(b_rc),
    .ap_start(b_start), .ap_ready(b_ready), .ap_done(b_done), .ap_idle(b_idle),
    .busy(b_busy), .done_all(b_done_all), .timeout_err(b_to), .run_idx(b_run),
    .dataset_idx(b_ds), .last_cycles(b_last));

  // Kernel a: ready one cycle after start is seen, done a_lat cycles after start.
  // It deliberately ignores reset so a late ap_done can reach the scheduler.
  initial begin
    a_ready = 1'b0; a_done = 1'b0;
    forever begin
      @(negedge ap_clk);
      a_ready = 1'b0; a_done = 1'b0;
      if (k_act) begin
        k_cnt++;
        if (k_cnt == 1) a_ready = 1'b1;
        if (k_cnt == a_lat) begin a_done = 1'b1; k_act = 0; end
      end else if (a_start) begin
        k_act = 1; k_cnt = 0;
      end
    end
  end

  // Kernel b: accepts and finishes in the same cycle ap_start is seen (done withheld on b_hold).
  initial begin
    b_ready = 1'b0; b_done = 1'b0;
    forever begin
      @(negedge ap_clk);
      b_ready = b_start;
      b_done  = b_start && !b_hold;
    end
  end

  initial begin
    forever begin
      @(negedge ap_clk); #1;
      if (a_start && !a_start_q) a_starts.push_back(cyc_n);
      a_start_q = a_start;
      if (a_done) begin a_dn_cnt++; a_last_dn = cyc_n; end
      if (a_done_all) begin a_da_cnt++; a_da_cyc = cyc_n; end
      if (b_start) b_hi++;
      if (b_start && !b_start_q) b_starts.push_back(cyc_n);
      b_start_q = b_start;
      if (b_done_all) b_da_cnt++;
    end
  end

  task automatic step();
    @(negedge ap_clk); #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_a_da(input int target, input string tag);
    int n = 0;
    while (a_da_cnt < target && n < 3000) begin step(); n++; end
    chk(tag, 64'(a_da_cnt >= target), 64'd1);
  endtask

  initial begin
    int c0, s, da0, st0, dn0, exp_ds, exp_run;
    ap_rst_n = 1'b0; a_trig = 0; b_trig = 0; a_rc = '0; b_rc = '0;
    a_idle = 1; b_idle = 1; a_lat = 100;
    step(); step();
    chk("rst_a_start", a_start, 0);    chk("rst_a_busy", a_busy, 0);
    chk("rst_a_done_all", a_done_all, 0); chk("rst_a_to", a_to, 0);
    chk("rst_a_run", a_run, 0);        chk("rst_a_ds", a_ds, 0);
    chk("rst_a_last", a_last, 0);      chk("rst_b_start", b_start, 0);
    ap_rst_n = 1'b1;
    repeat (4) step();

    // Three runs, 100-cycle kernel, gap 16.
    a_starts.delete(); da0 = a_da_cnt;
    a_rc = 16'd3; a_trig = 1; c0 = cyc_n;
    repeat (6) step();
    a_trig = 0;
    chk("t3_busy", a_busy, 1);
    wait_a_da(da0 + 1, "t3_wait");
    repeat (3) step();
    chk("t3_nstarts", a_starts.size(), 3);
    if (a_starts.size() == 3) begin
      chk("t3_first_start", a_starts[0], c0 + 4);
      for (int i = 1; i < 3; i++) chk("t3_spacing", a_starts[i] - a_starts[i-1], 117);
    end
    chk("t3_last", a_last, 101);  chk("t3_run", a_run, 3);
    chk("t3_ds", a_ds, 3);        chk("t3_ndone_all", a_da_cnt - da0, 1);
    chk("t3_done_all_cyc", a_da_cyc, a_last_dn + 1);
    chk("t3_busy_end", a_busy, 0);

    // Reset mid-run: outputs drop at once and a late ap_done is ignored.
    a_rc = 16'd2; a_trig = 1; st0 = a_starts.size() + 1;
    for (int n = 0; n < 50 && a_starts.size() < st0; n++) step();
    repeat (40) step();
    da0 = a_da_cnt; dn0 = a_dn_cnt;
    ap_rst_n = 1'b0; a_trig = 0;
    #1;
    chk("mr_start", a_start, 0); chk("mr_busy", a_busy, 0);
    chk("mr_run", a_run, 0);     chk("mr_ds", a_ds, 0);
    chk("mr_last", a_last, 0);   chk("mr_done_all", a_done_all, 0);
    repeat (3) step();
    ap_rst_n = 1'b1; st0 = a_starts.size();
    repeat (90) step();
    chk("mr_late_done_seen", 64'(a_dn_cnt > dn0), 1);
    chk("mr_post_run", a_run, 0); chk("mr_post_last", a_last, 0);
    chk("mr_post_starts", a_starts.size() - st0, 0);
    chk("mr_post_done_all", a_da_cnt - da0, 0);

    // Ten runs with a random kernel latency: dataset index walks and wraps.
    a_lat = $urandom_range(40, 8);
    a_starts.delete(); da0 = a_da_cnt; dn0 = a_dn_cnt; exp_ds = 0;
    a_rc = 16'd10; a_trig = 1;
    repeat (5) step();
    a_trig = 0;
    for (int i = 1; i <= 10; i++) begin
      for (int n = 0; n < 200 && a_dn_cnt < dn0 + i; n++) step();
      step();
      exp_ds = (exp_ds + 1) % 8;
      chk("t10_ds", a_ds, exp_ds);
      chk("t10_run", a_run, i);
      chk("t10_done_all", a_done_all, (i == 10));
    end
    step();
    chk("t10_done_all_1cyc", a_done_all, 0);
    chk("t10_last", a_last, a_lat + 1);
    chk("t10_nstarts", a_starts.size(), 10);
    for (int i = 1; i < a_starts.size(); i++) chk("t10_spacing", a_starts[i] - a_starts[i-1], a_lat + 17);

    // Continuous mode, trigger dropped during the fifth run.
    a_lat = $urandom_range(50, 20);
    a_starts.delete(); da0 = a_da_cnt;
    exp_ds = (exp_ds + 5) % 8;
    a_rc = '0; a_trig = 1;
    for (int n = 0; n < 1000 && a_starts.size() < 5; n++) step();
    repeat (5) step();
    a_trig = 0;
    wait_a_da(da0 + 1, "cont_wait");
    repeat (60) step();
    chk("cont_nstarts", a_starts.size(), 5);
    chk("cont_run", a_run, 5);
    chk("cont_ds", a_ds, exp_ds);
    chk("cont_last", a_last, a_lat + 1);
    chk("cont_ndone_all", a_da_cnt - da0, 1);

    // First launch held off while the kernel reports busy.
    a_lat = 10; a_idle = 0; st0 = a_starts.size(); da0 = a_da_cnt;
    a_rc = 16'd1; a_trig = 1;
    repeat (5) step();
    a_trig = 0;
    repeat (10) step();
    chk("wi_no_start", a_starts.size() - st0, 0);
    chk("wi_busy", a_busy, 1);
    a_idle = 1;
    wait_a_da(da0 + 1, "wi_wait");
    chk("wi_nstarts", a_starts.size() - st0, 1);
    chk("wi_run", a_run, 1);

    // Gap 0, ready and done in the start cycle: ap_start stays up for four runs.
    b_starts.delete(); exp_run = b_hi; da0 = b_da_cnt;
    b_rc = 16'd4; b_trig = 1; c0 = cyc_n;
    repeat (5) step();
    b_trig = 0;
    repeat (10) step();
    chk("b4_start_cycles", b_hi - exp_run, 4);
    chk("b4_nrises", b_starts.size(), 1);
    if (b_starts.size() == 1) chk("b4_first_start", b_starts[0], c0 + 4);
    chk("b4_last", b_last, 1);   chk("b4_run", b_run, 4);
    chk("b4_ds", b_ds, 4);       chk("b4_ndone_all", b_da_cnt - da0, 1);

    // Timeout with ap_done withheld, then relaunch clears the flag.
    b_starts.delete(); b_hold = 1; da0 = b_da_cnt;
    b_rc = 16'd1; b_trig = 1; c0 = cyc_n;
    repeat (5) step();
    b_trig = 0;
    s = c0 + 4;
    for (int n = 0; n < 200 && cyc_n < s + 63; n++) step();
    chk("to_reach", cyc_n, s + 63);
    chk("to_before_err", b_to, 0);  chk("to_before_busy", b_busy, 1);
    step();
    chk("to_err", b_to, 1);  chk("to_busy", b_busy, 0);  chk("to_start", b_start, 0);
    repeat (5) step();
    chk("to_sticky", b_to, 1);
    b_hold = 0; b_trig = 1; c0 = cyc_n;
    repeat (4) step();
    chk("to_relaunch_start", b_start, 1);
    chk("to_cleared", b_to, 0);
    step();
    b_trig = 0;
    repeat (4) step();
    chk("to_relaunch_done", b_da_cnt - da0, 1);
    chk("to_relaunch_run", b_run, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
